watch_time_core: RTL and testbench
==================================

Name: watch_time_core

Overview:
- Timekeeping and time-set datapath for the watch path; feeds the FND watch display controller.
- Produces msec/sec/min/hour, the blink phase counter `tick_cnt` and the edit cursor `i_num`.
- Runs the clock in normal mode. In edit mode (`sw_mode_2`=1) counting pauses and debounced buttons adjust min/hour digits.

Parameters:
- TICK_DIV, 1_000_000, system clocks per 10 ms tick (100 MHz → 100 Hz); ≥2.
- INIT_HOUR, 12, hour value loaded on reset (0..23).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- sw_mode_2  in  1  edit-mode enable (level)
- btn_up  in  1  debounced single-cycle pulse: increment field at cursor
- btn_down  in  1  debounced single-cycle pulse: decrement field at cursor
- btn_left  in  1  debounced single-cycle pulse: cursor toward higher digit
- btn_right  in  1  debounced single-cycle pulse: cursor toward lower digit
- msec  out  7  hundredths, 0..99
- sec  out  6  seconds, 0..59
- min  out  6  minutes, 0..59
- hour  out  5  hours, 0..23
- tick_cnt  out  6  blink phase, 0..39 (display blanks when ≥20)
- i_num  out  2  cursor: 0=min ones, 1=min tens, 2=hour ones, 3=hour tens

Behaviour:
- All state is registered; reset is synchronous and active-high.
- Reset values: msec=0, sec=0, min=0, hour=INIT_HOUR, tick_cnt=0, i_num=0, prescaler=0, sw_mode_2 history register=0.
- Prescaler counts 0..TICK_DIV-1 in every mode. `tick` is a 1-cycle pulse when count==TICK_DIV-1; count then returns to 0.
- `tick_cnt` advances on each tick and wraps 39→0.
- `tick_cnt` is cleared to 0 on the cycle after any of:
  - a rising edge of sw_mode_2;
  - an accepted button pulse while in edit mode.
  - This clear overrides that cycle's tick increment.
- Normal mode (sw_mode_2=0), on each tick, as a single-cycle cascade:
  - msec+1; on 99→0, sec+1.
  - sec 59→0 carries to min+1.
  - min 59→0 carries to hour+1.
  - hour 23→0.
  - 23:59:59.99 → 00:00:00.00 in one tick.
  - Buttons are ignored; i_num holds.
- Entering edit (rising edge of sw_mode_2):
  - msec and prescaler clear to 0 on the next cycle.
  - sec is kept.
  - Edge detection uses a registered copy of sw_mode_2.
- Edit mode (sw_mode_2=1):
  - No time increment on tick; tick_cnt still advances.
  - btn_left: i_num=(i_num+1) mod 4.
  - btn_right: i_num=(i_num-1) mod 4.
  - btn_left and btn_right in the same cycle: i_num unchanged.
  - btn_up / btn_down step size by cursor: i_num 0 → min ±1; 1 → min ±10; 2 → hour ±1; 3 → hour ±10.
  - Steps wrap modulo 60 (min) or 24 (hour), using width-extended arithmetic without underflow. Examples: min 55+10=5; min 3-10=53; hour 5-10=19; hour 20+10=6.
  - btn_up and btn_down in the same cycle: no change; tick_cnt is still cleared.
  - A cursor move and an up/down in the same cycle: the step uses the pre-move i_num, and both take effect.
- Exiting edit: counting resumes on the next tick with the edited values.
- Reset mid-edit: all outputs return to reset values; i_num=0.

Optional Feature:
- WATCH_SEC_ZERO_EN
  - Defined: any accepted btn_up/btn_down in edit mode also clears sec and msec to 0 in the same update.
  - Undefined: sec and msec are untouched by edits.

Decomposition:
- Shared package `watch_pkg` holds:
  - MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, BLINK_MAX=39, BLINK_ON_LIMIT=20;
  - cursor encodings CUR_MIN_1=0, CUR_MIN_10=1, CUR_HOUR_1=2, CUR_HOUR_10=3.
- One sub-module, `watch_tick_gen`: the TICK_DIV prescaler with sync clear input, outputting a 1-cycle tick.

Test Plan (TICK_DIV=4):
- Reset, INIT_HOUR=12:
  - Hold reset 3 cycles → hour=12, min=0, sec=0, msec=0, tick_cnt=0, i_num=0.
  - First tick appears 4 cycles after release.
- Full rollover:
  - Use edit to set 23:59, exit, run 5999 ticks → 23:59:59.99.
  - Next tick → 00:00:00.00.
- Min tens wrap:
  - Edit, min=55, btn_left once (i_num=1), btn_up → min=5, hour unchanged.
  - btn_down → min=55.
- Hour tens down:
  - hour=5, i_num=3, btn_down → hour=19.
  - btn_up+btn_down in the same cycle → hour stays 19 and tick_cnt=0.
- Cursor wrap:
  - i_num=0, btn_right → 3; btn_left → 0.
  - btn_left+btn_right together → 0.
  - Buttons in normal mode → no change to any output.
- Blink and pause:
  - In edit, 45 ticks → tick_cnt sequence 0..39,0..4, while msec/sec/min/hour stay frozen.
  - btn_up at tick_cnt=25 → tick_cnt=0 next cycle.
  - With WATCH_SEC_ZERO_EN, sec=30 before that press → sec=0.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared constants, cursor encoding and modular step helper for the watch timekeeping path.
package watch_pkg;

  localparam logic [6:0] MSEC_MAX       = 7'd99;
  localparam logic [5:0] SEC_MAX        = 6'd59;
  localparam logic [5:0] MIN_MAX        = 6'd59;
  localparam logic [4:0] HOUR_MAX       = 5'd23;
  localparam logic [5:0] BLINK_MAX      = 6'd39;
  localparam logic [5:0] BLINK_ON_LIMIT = 6'd20;

  typedef enum logic [1:0] {
    CUR_MIN_1   = 2'd0,
    CUR_MIN_10  = 2'd1,
    CUR_HOUR_1  = 2'd2,
    CUR_HOUR_10 = 2'd3
  } cursor_e;

  // Adds or subtracts step modulo `modulus`; a decrement becomes an add of (modulus-step) so nothing underflows.
  function automatic logic [6:0] step_wrap(input logic [6:0] val, input logic [6:0] step,
                                           input logic up, input logic [6:0] modulus);
    logic [6:0] sum;
    sum = val + (up ? step : (modulus - step));
    if (sum >= modulus) sum = sum - modulus;
    return sum;
  endfunction

endpackage

// File: rtl/watch_time_core_if.sv
// Button/mode inputs and time/blink/cursor outputs of the watch time core.
interface watch_time_core_if;
  logic       sw_mode_2;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [5:0] tick_cnt;
  logic [1:0] i_num;

  modport master (
    output sw_mode_2, btn_up, btn_down, btn_left, btn_right,
    input  msec, sec, min, hour, tick_cnt, i_num
  );

  modport slave (
    input  sw_mode_2, btn_up, btn_down, btn_left, btn_right,
    output msec, sec, min, hour, tick_cnt, i_num
  );
endinterface

// File: rtl/watch_tick_gen.sv
// Free-running TICK_DIV prescaler producing a one-cycle tick; clr_i restarts the count from 0.
module watch_tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/watch_time_core.sv
// Watch timekeeping and edit datapath: runs msec..hour, blink phase and edit cursor.
// Define WATCH_SEC_ZERO_EN to zero sec/msec whenever an edit step is applied.
module watch_time_core
  import watch_pkg::*;
#(
  parameter int TICK_DIV  = 1_000_000,
  parameter int INIT_HOUR = 12
) (
  input logic              clk,
  input logic              reset,
  watch_time_core_if.slave bus
);
`ifdef WATCH_SEC_ZERO_EN
  localparam bit SEC_ZERO = 1'b1;
`else
  localparam bit SEC_ZERO = 1'b0;
`endif

  logic       tick;
  logic       sw_q;
  logic [6:0] msec_q, msec_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] tick_cnt_q, tick_cnt_d;
  logic [1:0] i_num_q, i_num_d;
  logic       rise, edit, any_btn, step_up, step_dn, do_step;

  assign edit    = bus.sw_mode_2;
  assign rise    = bus.sw_mode_2 & ~sw_q;
  assign any_btn = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
  assign step_up = bus.btn_up & ~bus.btn_down;
  assign step_dn = bus.btn_down & ~bus.btn_up;
  assign do_step = edit & (step_up | step_dn);

  watch_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (rise),
    .tick_o (tick)
  );

  always_comb begin
    msec_d     = msec_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    tick_cnt_d = tick_cnt_q;
    i_num_d    = i_num_q;

    if (rise || (edit && any_btn)) tick_cnt_d = '0;
    else if (tick)                 tick_cnt_d = (tick_cnt_q == BLINK_MAX) ? 6'd0 : tick_cnt_q + 6'd1;

    if (!edit) begin
      // Full carry chain resolves in one tick, so 23:59:59.99 wraps straight to 00:00:00.00.
      if (tick) begin
        if (msec_q == MSEC_MAX) begin
          msec_d = '0;
          if (sec_q == SEC_MAX) begin
            sec_d = '0;
            if (min_q == MIN_MAX) begin
              min_d  = '0;
              hour_d = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          msec_d = msec_q + 7'd1;
        end
      end
    end else begin
      if (rise) msec_d = '0;

      if (bus.btn_left && !bus.btn_right)      i_num_d = i_num_q + 2'd1;
      else if (bus.btn_right && !bus.btn_left) i_num_d = i_num_q - 2'd1;

      // The step always follows the cursor as it was before this cycle's move.
      if (do_step) begin
        case (cursor_e'(i_num_q))
          CUR_MIN_1:   min_d  = 6'(step_wrap(7'(min_q), 7'd1, step_up, 7'(MIN_MAX) + 7'd1));
          CUR_MIN_10:  min_d  = 6'(step_wrap(7'(min_q), 7'd10, step_up, 7'(MIN_MAX) + 7'd1));
          CUR_HOUR_1:  hour_d = 5'(step_wrap(7'(hour_q), 7'd1, step_up, 7'(HOUR_MAX) + 7'd1));
          CUR_HOUR_10: hour_d = 5'(step_wrap(7'(hour_q), 7'd10, step_up, 7'(HOUR_MAX) + 7'd1));
          default: ;
        endcase
        if (SEC_ZERO) begin
          sec_d  = '0;
          msec_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_q       <= 1'b0;
      msec_q     <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= 5'(INIT_HOUR);
      tick_cnt_q <= '0;
      i_num_q    <= '0;
    end else begin
      sw_q       <= bus.sw_mode_2;
      msec_q     <= msec_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      tick_cnt_q <= tick_cnt_d;
      i_num_q    <= i_num_d;
    end
  end

  assign bus.msec     = msec_q;
  assign bus.sec      = sec_q;
  assign bus.min      = min_q;
  assign bus.hour     = hour_q;
  assign bus.tick_cnt = tick_cnt_q;
  assign bus.i_num    = i_num_q;
endmodule

// File: tb/tb_watch_time_core.sv
// Self-checking bench for watch_time_core with TICK_DIV=4, INIT_HOUR=12.
module tb_watch_time_core;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  watch_time_core_if bus();

  watch_time_core #(.TICK_DIV(TD), .INIT_HOUR(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  sw, up, dn, lf, rt;
    int    e_min, e_hour, e_inum;
  } vec_t;

  typedef struct {
    string name;
    int    e_min, e_hour, e_inum;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_btns();
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
  endtask

  task automatic do_reset(input logic sw_after);
    reset = 1'b1;
    clr_btns();
    bus.sw_mode_2 = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    bus.sw_mode_2 = sw_after;
  endtask

  function automatic vec_t mk(input string n, input logic up, input logic dn, input logic lf,
                              input logic rt, input int m, input int h, input int i);
    vec_t v;
    v.name = n; v.sw = 1'b1; v.up = up; v.dn = dn; v.lf = lf; v.rt = rt;
    v.e_min = m; v.e_hour = h; v.e_inum = i;
    return v;
  endfunction

  // Drive one vector for a single cycle; expectation goes through the scoreboard queue.
  task automatic apply(input vec_t v);
    exp_t e;
    bus.sw_mode_2 = v.sw;
    bus.btn_up = v.up; bus.btn_down = v.dn; bus.btn_left = v.lf; bus.btn_right = v.rt;
    e.name = v.name; e.e_min = v.e_min; e.e_hour = v.e_hour; e.e_inum = v.e_inum;
    sb.push_back(e);
    cyc();
    clr_btns();
    if (sb.size() == 0) begin
      chk({v.name, " sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({e.name, " min"}, int'(bus.min), e.e_min);
      chk({e.name, " hour"}, int'(bus.hour), e.e_hour);
      chk({e.name, " i_num"}, int'(bus.i_num), e.e_inum);
      chk({e.name, " tick_cnt"}, int'(bus.tick_cnt), 0);
    end
  endtask

  task automatic wait_msec_change(output bit ok);
    int prev;
    prev = int'(bus.msec);
    ok = 1'b0;
    for (int c = 0; c < 3 * TD; c++) begin
      cyc();
      if (int'(bus.msec) != prev) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_tcnt_change(output bit ok);
    int prev;
    prev = int'(bus.tick_cnt);
    ok = 1'b0;
    for (int c = 0; c < 3 * TD; c++) begin
      cyc();
      if (int'(bus.tick_cnt) != prev) begin ok = 1'b1; return; end
    end
  endtask

  vec_t tbl[27];

  initial begin
    bit ok;
    int m0, h0, p, exp_sec;

    tbl[0]  = mk("cur_right_wrap", 0, 0, 0, 1,  0, 12, 3);
    tbl[1]  = mk("cur_left_wrap",  0, 0, 1, 0,  0, 12, 0);
    tbl[2]  = mk("cur_left_right", 0, 0, 1, 1,  0, 12, 0);
    tbl[3]  = mk("min_dn1_wrap",   0, 1, 0, 0, 59, 12, 0);
    tbl[4]  = mk("min_dn1_a",      0, 1, 0, 0, 58, 12, 0);
    tbl[5]  = mk("min_dn1_b",      0, 1, 0, 0, 57, 12, 0);
    tbl[6]  = mk("min_dn1_c",      0, 1, 0, 0, 56, 12, 0);
    tbl[7]  = mk("min_dn1_d",      0, 1, 0, 0, 55, 12, 0);
    tbl[8]  = mk("cur_to_min10",   0, 0, 1, 0, 55, 12, 1);
    tbl[9]  = mk("min_up10_wrap",  1, 0, 0, 0,  5, 12, 1);
    tbl[10] = mk("min_dn10_wrap",  0, 1, 0, 0, 55, 12, 1);
    tbl[11] = mk("cur_to_hour1",   0, 0, 1, 0, 55, 12, 2);
    tbl[12] = mk("hour_dn1",       0, 1, 0, 0, 55, 11, 2);
    tbl[13] = mk("hour_up1",       1, 0, 0, 0, 55, 12, 2);
    tbl[14] = mk("cur_to_hour10",  0, 0, 1, 0, 55, 12, 3);
    tbl[15] = mk("hour_dn10",      0, 1, 0, 0, 55,  2, 3);
    tbl[16] = mk("cur_back_hour1", 0, 0, 0, 1, 55,  2, 2);
    tbl[17] = mk("hour_up1_a",     1, 0, 0, 0, 55,  3, 2);
    tbl[18] = mk("hour_up1_b",     1, 0, 0, 0, 55,  4, 2);
    tbl[19] = mk("hour_up1_c",     1, 0, 0, 0, 55,  5, 2);
    tbl[20] = mk("cur_hour10_b",   0, 0, 1, 0, 55,  5, 3);
    tbl[21] = mk("hour_dn10_wrap", 0, 1, 0, 0, 55, 19, 3);
    tbl[22] = mk("hour_up_and_dn", 1, 1, 0, 0, 55, 19, 3);
    tbl[23] = mk("hour_up10_wrap", 1, 0, 0, 0, 55,  5, 3);
    tbl[24] = mk("hour_up10",      1, 0, 0, 0, 55, 15, 3);
    tbl[25] = mk("move_and_step",  1, 0, 1, 0, 55,  1, 0);
    tbl[26] = mk("cur_to_min10_b", 0, 0, 1, 0, 55,  1, 1);

    // Reset state and first-tick latency
    bus.sw_mode_2 = 1'b0;
    clr_btns();
    reset = 1'b1;
    repeat (3) cyc();
    chk("rst hour", int'(bus.hour), 12);
    chk("rst min", int'(bus.min), 0);
    chk("rst sec", int'(bus.sec), 0);
    chk("rst msec", int'(bus.msec), 0);
    chk("rst tick_cnt", int'(bus.tick_cnt), 0);
    chk("rst i_num", int'(bus.i_num), 0);
    reset = 1'b0;
    repeat (3) cyc();
    chk("pre_first_tick msec", int'(bus.msec), 0);
    cyc();
    chk("first_tick msec", int'(bus.msec), 1);

    // Full rollover: set 23:59 in edit, then run 5999 ticks and one more
    do_reset(1'b1);
    cyc();
    apply(mk("roll_min59", 0, 1, 0, 0, 59, 12, 0));
    apply(mk("roll_cur3", 0, 0, 0, 1, 59, 12, 3));
    apply(mk("roll_h22", 1, 0, 0, 0, 59, 22, 3));
    apply(mk("roll_cur2", 0, 0, 0, 1, 59, 22, 2));
    apply(mk("roll_h23", 1, 0, 0, 0, 59, 23, 2));
    bus.sw_mode_2 = 1'b0;
    for (int k = 0; k < 5999; k++) begin
      wait_msec_change(ok);
      if (!ok) begin chk("roll tick timeout", 0, 1); break; end
    end
    chk("pre_roll hour", int'(bus.hour), 23);
    chk("pre_roll min", int'(bus.min), 59);
    chk("pre_roll sec", int'(bus.sec), 59);
    chk("pre_roll msec", int'(bus.msec), 99);
    wait_msec_change(ok);
    chk("roll tick seen", int'(ok), 1);
    chk("roll hour", int'(bus.hour), 0);
    chk("roll min", int'(bus.min), 0);
    chk("roll sec", int'(bus.sec), 0);
    chk("roll msec", int'(bus.msec), 0);

    // Table-driven edit-mode vectors
    do_reset(1'b1);
    cyc();
    chk("enter tick_cnt", int'(bus.tick_cnt), 0);
    chk("enter msec", int'(bus.msec), 0);
    for (int i = 0; i < 27; i++) apply(tbl[i]);

    // Buttons are ignored in normal mode
    bus.sw_mode_2 = 1'b0;
    repeat (10) cyc();
    for (int b = 0; b < 4; b++) begin
      p = int'(bus.tick_cnt);
      bus.btn_up = (b == 0); bus.btn_down = (b == 1);
      bus.btn_left = (b == 2); bus.btn_right = (b == 3);
      cyc();
      clr_btns();
      chk("normal_btn i_num", int'(bus.i_num), 1);
      chk("normal_btn min", int'(bus.min), 55);
      chk("normal_btn hour", int'(bus.hour), 1);
      if (p > 0 && p < 39)
        chk("normal_btn tick_cnt kept", int'((int'(bus.tick_cnt) == p) || (int'(bus.tick_cnt) == p + 1)), 1);
    end

    // Blink phase in edit with frozen time, then a press mid-phase
    do_reset(1'b0);
    for (int c = 0; c < 15000; c++) begin
      if (bus.sec == 6'd30) break;
      cyc();
    end
    chk("reach sec30", int'(bus.sec), 30);
    bus.sw_mode_2 = 1'b1;
    cyc();
    chk("blink enter tick_cnt", int'(bus.tick_cnt), 0);
    chk("blink enter msec", int'(bus.msec), 0);
    chk("blink enter sec", int'(bus.sec), 30);
    m0 = int'(bus.min);
    h0 = int'(bus.hour);
    for (int k = 1; k <= 45; k++) begin
      wait_tcnt_change(ok);
      if (!ok) begin chk("blink timeout", 0, 1); break; end
      chk($sformatf("blink step%0d", k), int'(bus.tick_cnt), k % 40);
    end
    chk("frozen msec", int'(bus.msec), 0);
    chk("frozen sec", int'(bus.sec), 30);
    chk("frozen min", int'(bus.min), m0);
    chk("frozen hour", int'(bus.hour), h0);
    for (int c = 0; c < 100 * TD; c++) begin
      if (bus.tick_cnt == 6'd25) break;
      cyc();
    end
    chk("reach tick_cnt25", int'(bus.tick_cnt), 25);
    bus.btn_up = 1'b1;
    cyc();
    clr_btns();
`ifdef WATCH_SEC_ZERO_EN
    exp_sec = 0;
`else
    exp_sec = 30;
`endif
    chk("press tick_cnt clr", int'(bus.tick_cnt), 0);
    chk("press min", int'(bus.min), (m0 + 1) % 60);
    chk("press sec", int'(bus.sec), exp_sec);
    chk("press msec", int'(bus.msec), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
